// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader
//
// Boot-time program loader placed in front of the machine's RAM and CPU.
// It takes a framed byte stream over a valid/ready handshake, writes the
// payload into RAM starting at address 0, verifies an 8-bit additive
// checksum and then releases the CPU from reset.
//
// Frame: length byte L, N payload bytes, checksum byte C.
//   N = L, except L = 0 means a full 2^ADDR_WIDTH byte image.
//   C = sum of the payload bytes mod 256 (length byte not included).
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   in_data     stream byte
//   in_valid    in_data valid this cycle
//   in_ready    loader accepts a byte this cycle (depends on state only)
//   restart     single-cycle request to leave DONE/ERROR for a new frame
//   cpu_halted  CPU halted flag; a reload from DONE needs it high
//   ram_we      RAM write strobe, one cycle per payload byte
//   ram_addr    RAM write address
//   ram_data    RAM write data
//   cpu_reset   active-high hold-in-reset for the CPU
//   busy        high while a frame is being received (LEN/LOAD/CHECK)
//   done        high after a frame with a good checksum
//   error       high after a frame with a bad checksum
//
// DATA_WIDTH is fixed at 8 by the frame format; it is a parameter only so
// the RAM-side port widths read naturally at the instantiation site.
// ---------------------------------------------------------------------------
module ram_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  restart,
    input  logic                  cpu_halted,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] ST_LEN   = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    // The byte counter is one bit wider than the address so it can hold a
    // full 2^ADDR_WIDTH byte frame.
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    logic [2:0]            state;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] sum;
    logic [ADDR_WIDTH:0]   frame_len;
    logic                  accept;

    // Ready depends on state alone so an upstream UART receiver never sees
    // a combinational loop through in_valid.
    assign in_ready = (state == ST_LEN) || (state == ST_LOAD) || (state == ST_CHECK);
    assign accept   = in_valid && in_ready;

    // Decode the length byte; zero stands for a full-size image.
    always_comb begin
        frame_len = (ADDR_WIDTH+1)'(in_data);
        if (in_data == '0) begin
            frame_len = FULL_COUNT;
        end
    end

    // Main loader state machine. Status flags and cpu_reset are registered
    // and only ever updated together with a state change, so they always
    // agree with the current state. ram_we defaults low and is raised for
    // exactly the cycle after a payload byte is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_LEN;
            remaining <= '0;
            addr      <= '0;
            sum       <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                ST_LEN: begin
                    if (accept) begin
                        remaining <= frame_len;
                        addr      <= '0;
                        sum       <= '0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= addr;
                        ram_data  <= in_data;
                        addr      <= addr + ADDR_ONE;
                        sum       <= sum + in_data;
                        remaining <= remaining - COUNT_ONE;
                        if (remaining == COUNT_ONE) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (in_data == sum) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Only reload once the CPU has stopped, so a running
                    // program is never overwritten underneath it.
                    if (restart && cpu_halted) begin
                        state     <= ST_LEN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        cpu_reset <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (restart) begin
                        state     <= ST_LEN;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        cpu_reset <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_LEN;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    error     <= 1'b0;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule
